zoom_job_sequencer: RTL and testbench



---
 rtl/zoom_job_sequencer_pkg.sv | 24 ++
 rtl/zoom_job_sequencer_if.sv | 37 +++
 rtl/zoom_job_sequencer_history_stack.sv | 63 ++++++
 rtl/zoom_job_sequencer.sv | 178 +++++++++++++++++
 tb/tb_zoom_job_sequencer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/zoom_job_sequencer_pkg.sv
// Shared types and constants for the zoom job sequencer: FSM states,
// zoom-level width and limits, and the switch-selected algorithm codes.
package zoom_job_sequencer_pkg;

  localparam int ZOOM_W       = 3;
  localparam int ZOOM_MAX     = 4;
  localparam int ZOOM_DEFAULT = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_RUN    = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ALG_NEAREST   = 2'b00,
    ALG_BILINEAR  = 2'b01,
    ALG_REPLICATE = 2'b10,
    ALG_DECIMATE  = 2'b11
  } alg_e;

endpackage

// File: rtl/zoom_job_sequencer_if.sv
// Request/datapath-control bundle between the front end (master) and the
// zoom job sequencer (slave).
interface zoom_job_sequencer_if #(
  parameter int ADDR_W = 19
);
  import zoom_job_sequencer_pkg::*;

  logic              zoom_in;
  logic              zoom_out;
  logic              return_prev;
  logic [1:0]        alg_sel;
  logic              sw_error;
  logic              proc_done;

  logic              proc_enable;
  logic [1:0]        alg_latched;
  logic              fb_wren;
  logic              fb_clear_sel;
  logic [ADDR_W-1:0] clr_addr;
  logic [ZOOM_W-1:0] zoom_level;
  logic              busy;
  logic              invalid_zoom_error;
  logic              has_run_once;

  modport master (
    output zoom_in, zoom_out, return_prev, alg_sel, sw_error, proc_done,
    input  proc_enable, alg_latched, fb_wren, fb_clear_sel, clr_addr,
           zoom_level, busy, invalid_zoom_error, has_run_once
  );

  modport slave (
    input  zoom_in, zoom_out, return_prev, alg_sel, sw_error, proc_done,
    output proc_enable, alg_latched, fb_wren, fb_clear_sel, clr_addr,
           zoom_level, busy, invalid_zoom_error, has_run_once
  );

endinterface

// File: rtl/zoom_job_sequencer_history_stack.sv
// Circular LIFO of earlier zoom levels; a push when full overwrites the oldest
// entry. Only built when ZOOM_HISTORY_EN is defined.
`ifdef ZOOM_HISTORY_EN
module zoom_history_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] pop_data,
  output logic         empty,
  output logic         full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] top_ptr;
  logic [CNT_W-1:0] count_q, count_d;

  // wr_ptr points at the next free slot; the top of stack sits just below it.
  always_comb begin
    top_ptr = (wr_ptr_q == '0) ? PTR_LAST : wr_ptr_q - PTR_W'(1);
  end

  assign pop_data = mem_q[top_ptr];
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_FULL);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      if (!full) count_d = count_q + CNT_W'(1);
    end else if (pop && !empty) begin
      wr_ptr_d = top_ptr;
      count_d  = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`endif

// File: rtl/zoom_job_sequencer.sv
// Zoom request sequencer: runs clear -> launch -> run -> finish jobs for the
// image datapath. Define ZOOM_HISTORY_EN to enable the zoom-level history stack.
module zoom_job_sequencer #(
`ifdef ZOOM_HISTORY_EN
  parameter int HIST_DEPTH   = 4,
`endif
  parameter int FB_DEPTH     = 307200,
  parameter int ADDR_W       = 19,
  parameter int ZOOM_MAX     = zoom_job_sequencer_pkg::ZOOM_MAX,
  parameter int ZOOM_DEFAULT = zoom_job_sequencer_pkg::ZOOM_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  zoom_job_sequencer_if.slave  bus
);
  import zoom_job_sequencer_pkg::*;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_DEPTH - 1);
  localparam logic [ZOOM_W-1:0] LVL_MAX  = ZOOM_W'(ZOOM_MAX);
  localparam logic [ZOOM_W-1:0] LVL_DEF  = ZOOM_W'(ZOOM_DEFAULT);

  state_e            state_q, state_d;
  logic [ZOOM_W-1:0] zoom_level_q, zoom_level_d;
  alg_e              alg_latched_q, alg_latched_d;
  logic              invalid_zoom_error_q, invalid_zoom_error_d;
  logic              has_run_once_q, has_run_once_d;
  logic              proc_enable_q, proc_enable_d;
  logic              fb_wren_q, fb_wren_d;
  logic              fb_clear_sel_q, fb_clear_sel_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              job_start;
  logic              req_any;

`ifdef ZOOM_HISTORY_EN
  logic              hist_push, hist_pop, hist_empty, hist_full;
  logic [ZOOM_W-1:0] hist_top;

  zoom_history_stack #(
    .DEPTH (HIST_DEPTH),
    .W     (ZOOM_W)
  ) u_history (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (hist_push),
    .pop       (hist_pop),
    .push_data (zoom_level_q),
    .pop_data  (hist_top),
    .empty     (hist_empty),
    .full      (hist_full)
  );
`endif

  assign req_any = bus.zoom_in | bus.zoom_out | bus.return_prev;

  // State register (also holds every registered output).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q              <= ST_IDLE;
      zoom_level_q         <= LVL_DEF;
      alg_latched_q        <= ALG_NEAREST;
      invalid_zoom_error_q <= 1'b0;
      has_run_once_q       <= 1'b0;
      proc_enable_q        <= 1'b0;
      fb_wren_q            <= 1'b0;
      fb_clear_sel_q       <= 1'b0;
      clr_addr_q           <= '0;
    end else begin
      state_q              <= state_d;
      zoom_level_q         <= zoom_level_d;
      alg_latched_q        <= alg_latched_d;
      invalid_zoom_error_q <= invalid_zoom_error_d;
      has_run_once_q       <= has_run_once_d;
      proc_enable_q        <= proc_enable_d;
      fb_wren_q            <= fb_wren_d;
      fb_clear_sel_q       <= fb_clear_sel_d;
      clr_addr_q           <= clr_addr_d;
    end
  end

  // Next-state: request arbitration in IDLE, job sequencing elsewhere.
  always_comb begin
    state_d              = state_q;
    zoom_level_d         = zoom_level_q;
    alg_latched_d        = alg_latched_q;
    invalid_zoom_error_d = invalid_zoom_error_q;
    job_start            = 1'b0;
`ifdef ZOOM_HISTORY_EN
    hist_push            = 1'b0;
    hist_pop             = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          if (!bus.sw_error) begin
            if (bus.return_prev) begin
`ifdef ZOOM_HISTORY_EN
              if (!hist_empty) begin
                zoom_level_d         = hist_top;
                hist_pop             = 1'b1;
                invalid_zoom_error_d = 1'b0;
                job_start            = 1'b1;
              end else begin
                invalid_zoom_error_d = 1'b1;
              end
`else
              if (zoom_level_q != LVL_DEF) begin
                zoom_level_d         = LVL_DEF;
                invalid_zoom_error_d = 1'b0;
                job_start            = 1'b1;
              end else begin
                invalid_zoom_error_d = 1'b1;
              end
`endif
            end else if (bus.zoom_in) begin
              if (zoom_level_q < LVL_MAX) begin
                zoom_level_d         = zoom_level_q + ZOOM_W'(1);
                invalid_zoom_error_d = 1'b0;
                job_start            = 1'b1;
`ifdef ZOOM_HISTORY_EN
                hist_push            = 1'b1;
`endif
              end else begin
                invalid_zoom_error_d = 1'b1;
              end
            end else begin
              if (zoom_level_q != '0) begin
                zoom_level_d         = zoom_level_q - ZOOM_W'(1);
                invalid_zoom_error_d = 1'b0;
                job_start            = 1'b1;
`ifdef ZOOM_HISTORY_EN
                hist_push            = 1'b1;
`endif
              end else begin
                invalid_zoom_error_d = 1'b1;
              end
            end
          end
        end else if (has_run_once_q && !bus.sw_error &&
                     (bus.alg_sel != alg_latched_q)) begin
          // A new algorithm on the switches re-renders at the current level.
          job_start = 1'b1;
        end
        if (job_start) begin
          state_d       = ST_CLEAR;
          alg_latched_d = alg_e'(bus.alg_sel);
        end
      end
      ST_CLEAR:  if (clr_addr_q == CLR_LAST) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_RUN;
      ST_RUN:    if (bus.proc_done) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registers line up with it.
  always_comb begin
    proc_enable_d  = (state_d == ST_LAUNCH) || (state_d == ST_RUN);
    fb_wren_d      = (state_d == ST_CLEAR)  || (state_d == ST_RUN);
    fb_clear_sel_d = (state_d == ST_CLEAR);
    clr_addr_d     = '0;
    if ((state_d == ST_CLEAR) && (state_q == ST_CLEAR)) begin
      clr_addr_d = clr_addr_q + ADDR_W'(1);
    end
    has_run_once_d = has_run_once_q | (state_q == ST_FINISH);
  end

  assign bus.proc_enable        = proc_enable_q;
  assign bus.alg_latched        = alg_latched_q;
  assign bus.fb_wren            = fb_wren_q;
  assign bus.fb_clear_sel       = fb_clear_sel_q;
  assign bus.clr_addr           = clr_addr_q;
  assign bus.zoom_level         = zoom_level_q;
  assign bus.busy               = (state_q != ST_IDLE);
  assign bus.invalid_zoom_error = invalid_zoom_error_q;
  assign bus.has_run_once       = has_run_once_q;

endmodule

// File: tb/tb_zoom_job_sequencer.sv
// Directed bench for zoom_job_sequencer with a shortened frame buffer;
// covers both the ZOOM_HISTORY_EN and the default build.
`timescale 1ns/1ps
module tb_zoom_job_sequencer;
  localparam int FB = 8;
  localparam int AW = 19;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #10 clk = ~clk;

  zoom_job_sequencer_if #(.ADDR_W(AW)) bus ();

  zoom_job_sequencer #(
    .FB_DEPTH (FB),
    .ADDR_W   (AW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Drive a one-cycle request; returns at the negedge after it was sampled.
  task automatic pulse(input logic zi, input logic zo, input logic rp);
    @(negedge clk);
    bus.zoom_in = zi; bus.zoom_out = zo; bus.return_prev = rp;
    @(negedge clk);
    bus.zoom_in = 1'b0; bus.zoom_out = 1'b0; bus.return_prev = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    while (!(bus.proc_enable && bus.fb_wren) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_reach_run"}, {31'd0, bus.proc_enable && bus.fb_wren}, 32'd1);
  endtask

  task automatic finish_job(input string tag);
    wait_run(tag);
    bus.proc_done = 1'b1;
    @(negedge clk);
    bus.proc_done = 1'b0;
    check_val({tag, "_finish_pen"}, {31'd0, bus.proc_enable}, 32'd0);
    check_val({tag, "_finish_busy"}, {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    check_val({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
    check_val({tag, "_ran_once"}, {31'd0, bus.has_run_once}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef ZOOM_HISTORY_EN
    int ret_exp [4] = '{2, 1, 0, 1};
`endif
    bus.zoom_in = 1'b0; bus.zoom_out = 1'b0; bus.return_prev = 1'b0;
    bus.alg_sel = 2'b00; bus.sw_error = 1'b0; bus.proc_done = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    check_val("rst_level", bus.zoom_level, 32'd2);
    check_val("rst_busy", bus.busy, 32'd0);
    check_val("rst_pen", bus.proc_enable, 32'd0);
    check_val("rst_wren", bus.fb_wren, 32'd0);
    check_val("rst_csel", bus.fb_clear_sel, 32'd0);
    check_val("rst_addr", bus.clr_addr, 32'd0);
    check_val("rst_alg", bus.alg_latched, 32'd0);
    check_val("rst_err", bus.invalid_zoom_error, 32'd0);
    check_val("rst_ran", bus.has_run_once, 32'd0);

    // First job: full sequence timing.
    pulse(1'b1, 1'b0, 1'b0);
    check_val("j1_level", bus.zoom_level, 32'd3);
    check_val("j1_busy", bus.busy, 32'd1);
    check_val("j1_csel", bus.fb_clear_sel, 32'd1);
    check_val("j1_wren", bus.fb_wren, 32'd1);
    check_val("j1_addr0", bus.clr_addr, 32'd0);
    check_val("j1_pen_clear", bus.proc_enable, 32'd0);
    for (int i = 1; i < FB; i++) begin
      @(negedge clk);
      check_val("j1_addr", bus.clr_addr, i);
      check_val("j1_csel_hold", bus.fb_clear_sel, 32'd1);
    end
    @(negedge clk);
    check_val("j1_launch_pen", bus.proc_enable, 32'd1);
    check_val("j1_launch_wren", bus.fb_wren, 32'd0);
    check_val("j1_launch_csel", bus.fb_clear_sel, 32'd0);
    @(negedge clk);
    check_val("j1_run_pen", bus.proc_enable, 32'd1);
    check_val("j1_run_wren", bus.fb_wren, 32'd1);
    check_val("j1_run_csel", bus.fb_clear_sel, 32'd0);
    check_val("j1_ran_before", bus.has_run_once, 32'd0);
    repeat (3) @(negedge clk);
    check_val("j1_run_wait", bus.proc_enable, 32'd1);
    finish_job("j1");

    // Upper limit, then step back down.
    pulse(1'b1, 1'b0, 1'b0);
    check_val("j2_level", bus.zoom_level, 32'd4);
    finish_job("j2");
    pulse(1'b1, 1'b0, 1'b0);
    check_val("max_err", bus.invalid_zoom_error, 32'd1);
    check_val("max_busy", bus.busy, 32'd0);
    check_val("max_level", bus.zoom_level, 32'd4);
    pulse(1'b0, 1'b1, 1'b0);
    check_val("dn_level", bus.zoom_level, 32'd3);
    check_val("dn_err", bus.invalid_zoom_error, 32'd0);
    check_val("dn_busy", bus.busy, 32'd1);
    finish_job("j3");

    // Requests during a job and proc_done in IDLE are ignored.
    pulse(1'b0, 1'b1, 1'b0);
    check_val("j4_level", bus.zoom_level, 32'd2);
    pulse(1'b1, 1'b0, 1'b0);
    check_val("clr_ignore_level", bus.zoom_level, 32'd2);
    wait_run("j4");
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    check_val("run_ignore_level", bus.zoom_level, 32'd2);
    check_val("run_ignore_busy", bus.busy, 32'd1);
    check_val("run_ignore_err", bus.invalid_zoom_error, 32'd0);
    finish_job("j4");
    check_val("j4_level_after", bus.zoom_level, 32'd2);
    bus.proc_done = 1'b1;
    @(negedge clk);
    bus.proc_done = 1'b0;
    check_val("idle_done_busy", bus.busy, 32'd0);
    check_val("idle_done_pen", bus.proc_enable, 32'd0);
    @(negedge clk);
    check_val("idle_done_busy2", bus.busy, 32'd0);

    // sw_error blocks the request.
    bus.sw_error = 1'b1;
    pulse(1'b1, 1'b0, 1'b0);
    check_val("swerr_busy", bus.busy, 32'd0);
    check_val("swerr_level", bus.zoom_level, 32'd2);
    check_val("swerr_err", bus.invalid_zoom_error, 32'd0);
    bus.sw_error = 1'b0;
    @(negedge clk);
    check_val("swerr_idle", bus.busy, 32'd0);

    // Algorithm change after the first run re-renders at the same level.
    bus.alg_sel = 2'b10;
    @(negedge clk);
    check_val("alg_busy", bus.busy, 32'd1);
    check_val("alg_latched", bus.alg_latched, 32'd2);
    check_val("alg_level", bus.zoom_level, 32'd2);
    check_val("alg_csel", bus.fb_clear_sel, 32'd1);
    finish_job("j5");
    @(negedge clk);
    check_val("alg_no_retrig", bus.busy, 32'd0);

    // Reset in the middle of CLEAR.
    pulse(1'b1, 1'b0, 1'b0);
    check_val("j6_level", bus.zoom_level, 32'd3);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_val("mrst_level", bus.zoom_level, 32'd2);
    check_val("mrst_busy", bus.busy, 32'd0);
    check_val("mrst_ran", bus.has_run_once, 32'd0);
    check_val("mrst_wren", bus.fb_wren, 32'd0);
    check_val("mrst_addr", bus.clr_addr, 32'd0);
    check_val("mrst_alg", bus.alg_latched, 32'd0);
    @(negedge clk);
    check_val("mrst_no_alg_job", bus.busy, 32'd0);

`ifdef ZOOM_HISTORY_EN
    pulse(1'b0, 1'b1, 1'b0);
    check_val("h_lvl1", bus.zoom_level, 32'd1);
    finish_job("h1");
    pulse(1'b0, 1'b1, 1'b0);
    check_val("h_lvl0", bus.zoom_level, 32'd0);
    finish_job("h2");
    pulse(1'b0, 1'b1, 1'b0);
    check_val("min_err", bus.invalid_zoom_error, 32'd1);
    check_val("min_busy", bus.busy, 32'd0);
    check_val("min_level", bus.zoom_level, 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    check_val("h_up1", bus.zoom_level, 32'd1);
    check_val("h_up1_err", bus.invalid_zoom_error, 32'd0);
    finish_job("h3");
    pulse(1'b1, 1'b0, 1'b0);
    check_val("h_up2", bus.zoom_level, 32'd2);
    finish_job("h4");
    pulse(1'b1, 1'b0, 1'b0);
    check_val("h_up3", bus.zoom_level, 32'd3);
    finish_job("h5");
    for (int i = 0; i < 4; i++) begin
      pulse(1'b0, 1'b0, 1'b1);
      check_val("h_ret_level", bus.zoom_level, ret_exp[i]);
      check_val("h_ret_busy", bus.busy, 32'd1);
      finish_job("h_ret");
    end
    pulse(1'b0, 1'b0, 1'b1);
    check_val("h_empty_err", bus.invalid_zoom_error, 32'd1);
    check_val("h_empty_busy", bus.busy, 32'd0);
    check_val("h_empty_level", bus.zoom_level, 32'd1);
    pulse(1'b1, 1'b0, 1'b0);
    check_val("h_pre_prio", bus.zoom_level, 32'd2);
    finish_job("h6");
    pulse(1'b1, 1'b0, 1'b1);
    check_val("prio_level", bus.zoom_level, 32'd1);
    check_val("prio_busy", bus.busy, 32'd1);
    finish_job("h7");
`else
    pulse(1'b0, 1'b0, 1'b1);
    check_val("ret_def_err", bus.invalid_zoom_error, 32'd1);
    check_val("ret_def_busy", bus.busy, 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    check_val("nh_up", bus.zoom_level, 32'd3);
    check_val("nh_up_err", bus.invalid_zoom_error, 32'd0);
    finish_job("nh1");
    pulse(1'b0, 1'b0, 1'b1);
    check_val("nh_ret_level", bus.zoom_level, 32'd2);
    check_val("nh_ret_busy", bus.busy, 32'd1);
    finish_job("nh2");
    pulse(1'b1, 1'b0, 1'b0);
    check_val("nh_up2", bus.zoom_level, 32'd3);
    finish_job("nh3");
    pulse(1'b1, 1'b0, 1'b1);
    check_val("prio_level", bus.zoom_level, 32'd2);
    check_val("prio_busy", bus.busy, 32'd1);
    finish_job("nh4");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
